// File: rtl/lfsr_resync_gen.sv
// lfsr_resync_gen: self-synchronising LFSR keystream generator.
// The state free-runs on a tap polynomial and is periodically reloaded from the
// last WIDTH ciphertext bits, so any keystream error heals after one clean period.
// Optional resync mismatch counter enabled by defining LFSR_ERRCNT_EN; without it
// err_cnt is tied to zero and no compare logic exists.
module lfsr_resync_gen #(
    parameter int unsigned     WIDTH         = 8,
    parameter logic [WIDTH:0]  POLY          = 9'b1_0111_0001,
    parameter int unsigned     RESYNC_PERIOD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             en,
    input  logic             ctext_in,
    output logic [WIDTH-1:0] z_out,
    output logic             resync_pulse,
    output logic             locked,
    output logic [7:0]       err_cnt
);

    localparam int unsigned      CNT_W    = $clog2(RESYNC_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESYNC_PERIOD - 1);

    typedef enum logic {StUnlocked, StLocked} lock_state_e;

    lock_state_e      r_fsm;
    lock_state_e      w_fsm_next;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_ctext;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    logic             w_fb;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_ctext_next;
    logic             w_at_last;
    logic             w_resync_step;

    // Feedback parity over tapped bits, forced to 1 on all-zero state so it never stalls.
    always_comb begin
        logic w_par;
        w_par = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_par = w_par ^ (POLY[i+1] & r_state[i]);
        end
        w_fb = w_par | (r_state == '0);
    end

    assign w_step        = {r_state[WIDTH-2:0], w_fb};
    assign w_ctext_next  = {r_ctext[WIDTH-2:0], ctext_in};
    assign w_at_last     = (r_cnt == CNT_LAST);
    // Resync only happens when no reset or reload pre-empts the enabled step.
    assign w_resync_step = !rst && !seed_load && en && w_at_last;

    // Lock FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= StUnlocked;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Lock FSM next state: reload unlocks, any completed resync locks.
    always_comb begin
        w_fsm_next = r_fsm;
        if (seed_load) begin
            w_fsm_next = StUnlocked;
        end else if (w_resync_step) begin
            w_fsm_next = StLocked;
        end
    end

    // Datapath: LFSR state, ciphertext history, step counter and resync strobe.
    always_ff @(posedge clk) begin
        if (rst || seed_load) begin
            r_state <= seed;
            r_ctext <= '0;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
        end else if (en) begin
            r_ctext <= w_ctext_next;
            if (w_at_last) begin
                // Bit arriving this cycle is part of the reloaded word.
                r_state <= w_ctext_next;
                r_cnt   <= '0;
                r_pulse <= 1'b1;
            end else begin
                r_state <= w_step;
                r_cnt   <= r_cnt + 1'b1;
                r_pulse <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign z_out        = r_state;
    assign resync_pulse = r_pulse;
    assign locked       = (r_fsm == StLocked);

`ifdef LFSR_ERRCNT_EN
    logic [7:0] r_err;

    // Count resyncs where the free-running value disagrees with the ciphertext
    // word; the unlocking resync is skipped because the state was only a seed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else if (w_resync_step && (r_fsm == StLocked) && (w_step != w_ctext_next)
                     && (r_err != 8'hFF)) begin
            r_err <= r_err + 8'd1;
        end
    end

    assign err_cnt = r_err;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_lfsr_resync_gen.sv
// Self-checking bench for lfsr_resync_gen (default parameters). A queue-based
// reference model tracks expected outputs; a negedge process compares every cycle,
// and literal expectations pin the model. Define LFSR_ERRCNT_EN to exercise err_cnt.
module tb_lfsr_resync_gen;

    localparam int unsigned    W      = 8;
    localparam int unsigned    PERIOD = 8;
    localparam logic [W:0]     TB_POLY = 9'b1_0111_0001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         seed_load = 1'b0;
    logic         en = 1'b0;
    logic         ctext_in = 1'b0;
    logic [W-1:0] seed = '0;
    logic [W-1:0] z_out;
    logic         resync_pulse;
    logic         locked;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [W-1:0] m_z = '0;
    bit           m_locked = 1'b0;
    bit           m_pulse = 1'b0;
    int           m_err = 0;
    int           m_steps = 0;
    bit           m_hist[$];
    bit           chk_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_resync_gen dut (
        .clk          (clk),
        .rst          (rst),
        .seed         (seed),
        .seed_load    (seed_load),
        .en           (en),
        .ctext_in     (ctext_in),
        .z_out        (z_out),
        .resync_pulse (resync_pulse),
        .locked       (locked),
        .err_cnt      (err_cnt)
    );

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        logic [W-1:0] taps;
        logic         fb;
        taps = TB_POLY[W:1];
        fb   = (($countones(s & taps) % 2) == 1) || (s == '0);
        return {s[W-2:0], fb};
    endfunction

    // Last W ciphertext bits, oldest in the MSB.
    function automatic logic [W-1:0] hist_word();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < m_hist.size(); i++) w = {w[W-2:0], m_hist[i]};
        return w;
    endfunction

    function automatic bit own_bit();
        logic [W-1:0] n;
        n = lfsr_next(m_z);
        return n[0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reload(input bit clr_err);
        m_z      = seed;
        m_hist   = {};
        for (int i = 0; i < int'(W); i++) m_hist.push_back(1'b0);
        m_steps  = 0;
        m_pulse  = 1'b0;
        m_locked = 1'b0;
        if (clr_err) m_err = 0;
    endtask

    task automatic model_update();
        logic [W-1:0] free;
        logic [W-1:0] word;
        if (rst) begin
            model_reload(1'b1);
        end else if (seed_load) begin
            model_reload(1'b0);
        end else if (en) begin
            m_hist.push_back(ctext_in);
            if (m_hist.size() > int'(W)) void'(m_hist.pop_front());
            word = hist_word();
            free = lfsr_next(m_z);
            m_steps++;
            if (m_steps == int'(PERIOD)) begin
`ifdef LFSR_ERRCNT_EN
                if (m_locked && (free != word) && (m_err < 255)) m_err++;
`endif
                m_z      = word;
                m_pulse  = 1'b1;
                m_locked = 1'b1;
                m_steps  = 0;
            end else begin
                m_z     = free;
                m_pulse = 1'b0;
            end
        end else begin
            m_pulse = 1'b0;
        end
    endtask

    task automatic cyc(input bit r, input bit sl, input bit e, input bit c,
                       input logic [W-1:0] sd);
        rst = r; seed_load = sl; en = e; ctext_in = c; seed = sd;
        @(posedge clk);
        #1;
        model_update();
        chk_en = 1'b1;
    endtask

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("z_out", 32'(z_out), 32'(m_z));
            check("resync_pulse", 32'(resync_pulse), 32'(m_pulse));
            check("locked", 32'(locked), 32'(m_locked));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
        end
    end

    initial begin
        logic [W-1:0] exp_seq [4];
        logic [7:0]   pat;
        int           zero_seen;
        int           en_seen;

        // Plain stepping from seed 01
        exp_seq[0] = 8'h02; exp_seq[1] = 8'h04; exp_seq[2] = 8'h08; exp_seq[3] = 8'h11;
        cyc(1, 0, 0, 0, 8'h01);
        check("reset_z", 32'(z_out), 32'h01);
        check("reset_locked", 32'(locked), 32'h0);
        check("reset_pulse", 32'(resync_pulse), 32'h0);
        check("reset_err", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0, 8'h01);
            check("step_seq", 32'(z_out), 32'(exp_seq[i]));
        end

        // Zero protection; ciphertext follows the generator so resyncs stay nonzero
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        check("zero_protect", 32'(z_out), 32'h01);
        zero_seen = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1, own_bit(), 8'h00);
            if (z_out == '0) zero_seen++;
        end
        check("never_zero", 32'(zero_seen), 32'h0);

        // Full-period resync with alternating ciphertext
        cyc(1, 0, 0, 0, 8'h01);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i % 2 == 0), 8'h01);
        check("resync_word", 32'(z_out), 32'hAA);
        check("resync_pulse_hi", 32'(resync_pulse), 32'h1);
        check("resync_locked", 32'(locked), 32'h1);
        cyc(0, 0, 0, 0, 8'h01);
        check("resync_pulse_once", 32'(resync_pulse), 32'h0);
        check("hold_z", 32'(z_out), 32'hAA);

        // Enable toggling: resync on 8th enabled edge, not 8th clock
        cyc(1, 0, 0, 0, 8'h01);
        pat = 8'hCC;
        en_seen = 0;
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 0) begin
                cyc(0, 0, 1, pat[7 - en_seen], 8'h01);
                en_seen++;
            end else begin
                cyc(0, 0, 0, 1'($urandom), 8'h01);
            end
            if (k == 12) check("toggle_no_early_pulse", 32'(resync_pulse), 32'h0);
            if (k == 14) begin
                check("toggle_word", 32'(z_out), 32'hCC);
                check("toggle_pulse", 32'(resync_pulse), 32'h1);
            end
            if (k == 15) check("toggle_hold", 32'(z_out), 32'hCC);
        end

        // seed_load colliding with a resync step
        cyc(1, 0, 0, 0, 8'h01);
        for (int i = 0; i < 15; i++) cyc(0, 0, 1, 1'($urandom), 8'h01);
        cyc(0, 1, 1, 1'($urandom), 8'h5A);
        check("reload_z", 32'(z_out), 32'h5A);
        check("reload_locked", 32'(locked), 32'h0);
        check("reload_pulse", 32'(resync_pulse), 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 1'($urandom), 8'h5A);
            if (i == 6) check("reload_cnt_restart_lo", 32'(resync_pulse), 32'h0);
            if (i == 7) check("reload_cnt_restart_hi", 32'(resync_pulse), 32'h1);
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 255) == 0), ($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom));
        end

`ifdef LFSR_ERRCNT_EN
        // Mismatch counter behaviour
        cyc(1, 0, 0, 0, 8'h3C);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1'($urandom), 8'h3C);
        for (int i = 0; i < 24; i++) cyc(0, 0, 1, own_bit(), 8'h3C);
        check("err_clean", 32'(err_cnt), 32'h0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i == 3) ? !own_bit() : own_bit(), 8'h3C);
        check("err_one", 32'(err_cnt), 32'h1);
        for (int p = 0; p < 300; p++) begin
            for (int i = 0; i < 8; i++) cyc(0, 0, 1, (i == 7) ? !own_bit() : own_bit(), 8'h3C);
        end
        check("err_sat", 32'(err_cnt), 32'hFF);
        cyc(0, 1, 0, 0, 8'h3C);
        check("err_hold_seed_load", 32'(err_cnt), 32'hFF);
        cyc(1, 0, 0, 0, 8'h3C);
        check("err_rst", 32'(err_cnt), 32'h0);
`endif

        cyc(0, 0, 0, 0, 8'h00);
        @(negedge clk);
        chk_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
